node_update_engine: RTL and testbench



---
 rtl/node_mem_pkg.sv | 37 +++
 rtl/nue_fwd_pipe.sv | 41 ++++
 rtl/node_update_engine.sv | 143 ++++++++++++++
 tb/tb_node_update_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/node_mem_pkg.sv
// Shared types and helpers for the node memory update engine.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package node_mem_pkg;

  localparam int NODE_ADDR_W = 10;
  localparam int NODE_DATA_W = 36;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CLEAR
  } nue_state_t;

  // Update travelling from acceptance to the memory sample point
  typedef struct packed {
    logic                   valid;
    logic [NODE_ADDR_W-1:0] addr;
    logic [NODE_DATA_W-1:0] delta;
  } upd_rec_t;

  // Computed result whose write is not yet visible to a new read
  typedef struct packed {
    logic                   valid;
    logic [NODE_ADDR_W-1:0] addr;
    logic [NODE_DATA_W-1:0] data;
  } fwd_ent_t;

  // Unsigned add that clamps to all-ones instead of wrapping
  function automatic logic [NODE_DATA_W-1:0] sat_add(input logic [NODE_DATA_W-1:0] a,
                                                     input logic [NODE_DATA_W-1:0] b);
    logic [NODE_DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[NODE_DATA_W] ? {NODE_DATA_W{1'b1}} : sum[NODE_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/nue_fwd_pipe.sv
// Forwarding window: DEPTH-deep shift register of recent write-back results.
// Latency: lookup is combinational; a pushed result is visible from the next cycle.
// Backpressure: none, shifts every cycle.
module nue_fwd_pipe
  import node_mem_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  fwd_ent_t               push,
  input  logic [NODE_ADDR_W-1:0] look_addr,
  output logic                   hit,
  output logic [NODE_DATA_W-1:0] hit_data
);

  fwd_ent_t ent [DEPTH];

  // Entry 0 is the youngest result; older results age toward DEPTH-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      ent[0] <= push;
      for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
    end
  end

  // Scan oldest to youngest so the youngest matching result wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent[i].valid && ent[i].addr == look_addr) begin
        hit      = 1'b1;
        hit_data = ent[i].data;
      end
    end
  end

endmodule

// File: rtl/node_update_engine.sv
// Read-modify-write update engine on port A, host queries and bulk clear on port B.
// Latency: write-back registered RD_LAT edges after acceptance; query response likewise.
// Backpressure: readies drop only while draining for / running a clear; rsp has none.
module node_update_engine
  import node_mem_pkg::*;
#(
  parameter int ADDR_W = NODE_ADDR_W,
  parameter int DATA_W = NODE_DATA_W,
  parameter int RD_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_delta,
  input  logic              qry_valid,
  output logic              qry_ready,
  input  logic [ADDR_W-1:0] qry_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              busy,
  output logic [31:0]       upd_count,
  output logic [ADDR_W-1:0] rdaddr_a,
  output logic [ADDR_W-1:0] wraddr_a,
  output logic              wren_a,
  output logic [DATA_W-1:0] wrdata_a,
  input  logic [DATA_W-1:0] q_a,
  output logic [ADDR_W-1:0] rdaddr_b,
  output logic [ADDR_W-1:0] wraddr_b,
  output logic              wren_b,
  output logic [DATA_W-1:0] wrdata_b,
  input  logic [DATA_W-1:0] q_b
);

  nue_state_t        state, state_nxt;
  upd_rec_t          req [RD_LAT];
  logic [RD_LAT-1:0] qry_pipe;
  logic [ADDR_W-1:0] clr_addr;
  logic              upd_fire, qry_fire, req_any, inflight;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data, old_val, new_val;
  fwd_ent_t          fwd_push;

  assign upd_ready = (state == RUN) && !rst;
  assign qry_ready = (state == RUN) && !rst;
  assign upd_fire  = upd_valid && upd_ready;
  assign qry_fire  = qry_valid && qry_ready;
  assign clr_busy  = (state != RUN);

  // Any update between acceptance and write-back register
  always_comb begin
    req_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) req_any = req_any | req[i].valid;
  end

  assign busy     = req_any || wren_a;
  assign inflight = busy || (|qry_pipe) || rsp_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Clear sequencing: drain in-flight work, then sweep every address
  always_comb begin
    state_nxt = state;
    wren_b    = 1'b0;
    wraddr_b  = '0;
    wrdata_b  = '0;
    case (state)
      RUN:     if (clr_start) state_nxt = DRAIN;
      DRAIN:   if (!inflight) state_nxt = CLEAR;
      CLEAR: begin
        wren_b   = 1'b1;
        wraddr_b = clr_addr;
        if (clr_addr == {ADDR_W{1'b1}}) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Clear address counter, parked at 0 so every sweep starts from the bottom
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
    else                     clr_addr <= '0;
  end

  // Older result that the memory read cannot yet see overrides q_a
  assign old_val  = fwd_hit ? fwd_data : q_a;
  assign new_val  = sat_add(old_val, req[RD_LAT-1].delta);
  assign fwd_push = '{valid: req[RD_LAT-1].valid, addr: req[RD_LAT-1].addr, data: new_val};

  nue_fwd_pipe #(.DEPTH(RD_LAT)) u_fwd (
    .clk      (clk),
    .rst      (rst),
    .push     (fwd_push),
    .look_addr(req[RD_LAT-1].addr),
    .hit      (fwd_hit),
    .hit_data (fwd_data)
  );

  // Update pipeline: launch the read, age the request, register the write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) req[i] <= '0;
      rdaddr_a  <= '0;
      wren_a    <= 1'b0;
      wraddr_a  <= '0;
      wrdata_a  <= '0;
      upd_count <= '0;
    end else begin
      req[0] <= '{valid: upd_fire, addr: upd_addr, delta: upd_delta};
      for (int i = 1; i < RD_LAT; i++) req[i] <= req[i-1];
      if (upd_fire) rdaddr_a <= upd_addr;
      wren_a    <= req[RD_LAT-1].valid;
      wraddr_a  <= req[RD_LAT-1].valid ? req[RD_LAT-1].addr : '0;
      wrdata_a  <= req[RD_LAT-1].valid ? new_val : '0;
      upd_count <= upd_count + {31'd0, wren_a};
    end
  end

  // Query pipeline: raw port B read, response registered with the data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qry_pipe  <= '0;
      rdaddr_b  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      qry_pipe[0] <= qry_fire;
      for (int i = 1; i < RD_LAT; i++) qry_pipe[i] <= qry_pipe[i-1];
      if (qry_fire) rdaddr_b <= qry_addr;
      rsp_valid <= qry_pipe[RD_LAT-1];
      rsp_data  <= qry_pipe[RD_LAT-1] ? q_b : '0;
    end
  end

endmodule

// File: tb/tb_node_update_engine.sv
// Directed bench for node_update_engine with a 3-cycle-latency memory model.
// Latency: checks write-back at acceptance+3 and query response at acceptance+3.
// Backpressure: checks readies around clear and reset.
module tb_node_update_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid, upd_ready;
  logic [9:0]  upd_addr;
  logic [35:0] upd_delta;
  logic        qry_valid, qry_ready;
  logic [9:0]  qry_addr;
  logic        rsp_valid;
  logic [35:0] rsp_data;
  logic        clr_start, clr_busy, busy;
  logic [31:0] upd_count;
  logic [9:0]  rdaddr_a, wraddr_a, rdaddr_b, wraddr_b;
  logic        wren_a, wren_b;
  logic [35:0] wrdata_a, wrdata_b, q_a, q_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_k  = 0;

  // memory model
  logic [35:0] mem [1024];
  logic [35:0] a_p0, a_p1, b_p0, b_p1;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [35:0] pre_data = '0;

  assign q_a = a_p1;
  assign q_b = b_p1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reads see memory before this edge's writes, then two more register stages
  always @(posedge clk) begin
    a_p0 <= mem[rdaddr_a];
    a_p1 <= a_p0;
    b_p0 <= mem[rdaddr_b];
    b_p1 <= b_p0;
    if (wren_a) mem[wraddr_a] <= wrdata_a;
    if (wren_b) mem[wraddr_b] <= wrdata_b;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  node_update_engine #(.ADDR_W(10), .DATA_W(36), .RD_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_delta(upd_delta),
    .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_addr(qry_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .busy(busy), .upd_count(upd_count),
    .rdaddr_a(rdaddr_a), .wraddr_a(wraddr_a), .wren_a(wren_a), .wrdata_a(wrdata_a), .q_a(q_a),
    .rdaddr_b(rdaddr_b), .wraddr_b(wraddr_b), .wren_b(wren_b), .wrdata_b(wrdata_b), .q_b(q_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [35:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step(1);
    pre_we = 1'b0;
  endtask

  task automatic upd(input logic [9:0] a, input logic [35:0] d);
    upd_valid = 1'b1; upd_addr = a; upd_delta = d;
    step(1);
    upd_valid = 1'b0;
    last_k = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin step(1); n++; end
    chk("idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic qry(input logic [9:0] a, input logic [35:0] exp, input string tag);
    int k;
    int n = 0;
    qry_valid = 1'b1; qry_addr = a;
    step(1);
    qry_valid = 1'b0;
    k = cyc;
    while (!rsp_valid && n < 10) begin step(1); n++; end
    chk({tag, "_lat"}, 64'(cyc - k), 64'd3);
    chk(tag, {28'd0, rsp_data}, {28'd0, exp});
  endtask

  task automatic chk_wr(input string tag, input logic [9:0] a, input logic [35:0] d);
    chk({tag, "_wren"}, {63'd0, wren_a}, 64'd1);
    chk({tag, "_addr"}, {54'd0, wraddr_a}, {54'd0, a});
    chk({tag, "_data"}, {28'd0, wrdata_a}, {28'd0, d});
  endtask

  initial begin
    rst = 1'b1; upd_valid = 1'b0; upd_addr = '0; upd_delta = '0;
    qry_valid = 1'b0; qry_addr = '0; clr_start = 1'b0;
    step(3);
    chk("rst_wren_a", {63'd0, wren_a}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_upd_count", {32'd0, upd_count}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_wren_b", {63'd0, wren_b}, 64'd0);
    chk("rst_clr_busy", {63'd0, clr_busy}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_upd_ready", {63'd0, upd_ready}, 64'd1);
    chk("rst_qry_ready", {63'd0, qry_ready}, 64'd1);

    // single update: 0x10 + 0x20
    preload(5, 36'h10);
    upd(5, 36'h20);
    chk("t1_busy_on", {63'd0, busy}, 64'd1);
    step(2);
    chk("t1_no_early_wr", {63'd0, wren_a}, 64'd0);
    step(1);
    chk_wr("t1_wr", 5, 36'h30);
    step(1);
    chk("t1_count", {32'd0, upd_count}, 64'd1);
    chk("t1_busy_off", {63'd0, busy}, 64'd0);
    chk("t1_wren_off", {63'd0, wren_a}, 64'd0);

    // back-to-back same address: 1 -> 2 -> 4 -> 7
    preload(7, 36'h1);
    upd(7, 36'h1); upd(7, 36'h2); upd(7, 36'h3);
    step(1); chk_wr("t2_w0", 7, 36'h2);
    step(1); chk_wr("t2_w1", 7, 36'h4);
    step(1); chk_wr("t2_w2", 7, 36'h7);
    step(1);
    chk("t2_busy_off", {63'd0, busy}, 64'd0);
    qry(7, 36'h7, "t2_qry");

    // interleaved hazard on two addresses
    preload(3, 36'h0); preload(4, 36'h0);
    upd(3, 36'h1); upd(4, 36'h1); upd(3, 36'h1); upd(4, 36'h1);
    chk_wr("t3_w0", 3, 36'h1);
    step(1); chk_wr("t3_w1", 4, 36'h1);
    step(1); chk_wr("t3_w2", 3, 36'h2);
    step(1); chk_wr("t3_w3", 4, 36'h2);
    wait_idle();
    qry(3, 36'h2, "t3_qry3");
    qry(4, 36'h2, "t3_qry4");
    chk("t3_count", {32'd0, upd_count}, 64'd8);

    // saturation: carry clamps, exact max does not need clamping
    preload(9, 36'hFFFFFFFF0);
    upd(9, 36'h20);
    step(3); chk_wr("t4_sat", 9, 36'hFFFFFFFFF);
    preload(12, 36'hFFFFFFFF0);
    upd(12, 36'hF);
    step(3); chk_wr("t4_edge", 12, 36'hFFFFFFFFF);
    wait_idle();
    qry(9, 36'hFFFFFFFFF, "t4_qry");

    // clear with two updates in flight; clr_start coincides with the second
    preload(10, 36'h100); preload(11, 36'h200); preload(1023, 36'h55);
    upd(10, 36'h5);
    clr_start = 1'b1;
    upd(11, 36'h6);
    clr_start = 1'b0;
    chk("t5_rdy_low", {63'd0, upd_ready}, 64'd0);
    chk("t5_clr_busy", {63'd0, clr_busy}, 64'd1);
    begin
      int nb = 0;
      int n = 0;
      int ovl = 0;
      logic [35:0] w10 = '0;
      logic [35:0] w11 = '0;
      while (clr_busy && n < 1500) begin
        if (wren_b) nb++;
        if (wren_a && wraddr_a == 10'd10) w10 = wrdata_a;
        if (wren_a && wraddr_a == 10'd11) w11 = wrdata_a;
        if (wren_a && wren_b) ovl++;
        step(1);
        n++;
      end
      chk("t5_clr_done", {63'd0, clr_busy}, 64'd0);
      chk("t5_wren_b_cnt", 64'(nb), 64'd1024);
      chk("t5_upd10", {28'd0, w10}, 64'h105);
      chk("t5_upd11", {28'd0, w11}, 64'h206);
      chk("t5_overlap", 64'(ovl), 64'd0);
      chk("t5_upd_ready", {63'd0, upd_ready}, 64'd1);
      chk("t5_qry_ready", {63'd0, qry_ready}, 64'd1);
    end
    qry(10, 36'h0, "t5_qry10");
    qry(11, 36'h0, "t5_qry11");
    qry(1023, 36'h0, "t5_qry1023");
    chk("t5_count", {32'd0, upd_count}, 64'd12);

    // reset with three updates and a query in flight
    preload(20, 36'h0);
    upd_valid = 1'b1; upd_addr = 10'd20; upd_delta = 36'h1;
    qry_valid = 1'b1; qry_addr = 10'd20;
    step(1);
    qry_valid = 1'b0;
    step(2);
    upd_valid = 1'b0;
    step(1);
    chk("t6_pre_wren", {63'd0, wren_a}, 64'd1);
    chk("t6_pre_rsp", {63'd0, rsp_valid}, 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_wren_a", {63'd0, wren_a}, 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("t6_upd_count", {32'd0, upd_count}, 64'd0);
    step(2);
    rst = 1'b0;
    #1;
    chk("t6_upd_ready", {63'd0, upd_ready}, 64'd1);
    step(6);
    chk("t6_busy_after", {63'd0, busy}, 64'd0);
    chk("t6_count_after", {32'd0, upd_count}, 64'd0);
    qry(20, 36'h0, "t6_qry20");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
